// File: rtl/core_io_arbiter.sv
// core_io_arbiter
//   Round-robin owner of the shared external I/O port for NCORE cores.
//   Exactly one core owns the bus per transfer. The scan for the next owner
//   starts at ptr, and ptr moves past each served core, so every requester
//   is reached within one rotation.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   out_req      per-core output request (core i's out_en)
//   out_data     per-core signed output word, core i at [i*DW +: DW]
//   in_req       per-core input request (core i's req_in)
//   out_gnt      one-hot, core i's output word is accepted this cycle
//   in_gnt       one-hot, core i latches the broadcast io_in this cycle
//   io_out       registered signed shared output word
//   io_out_vld   io_out holds a word for the downstream
//   io_out_rdy   downstream accepts io_out while io_out_vld is high
//   io_in_vld    an external input word is present this cycle
//   busy         a transfer is in progress (state != IDLE)
//   cur_core     index of the current owner
module core_io_arbiter #(
  parameter int NCORE = 25,
  parameter int DW    = 32,
  parameter int IW    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCORE-1:0]        out_req,
  input  logic [NCORE*DW-1:0]     out_data,
  input  logic [NCORE-1:0]        in_req,
  output logic [NCORE-1:0]        out_gnt,
  output logic [NCORE-1:0]        in_gnt,
  output logic signed [DW-1:0]    io_out,
  output logic                    io_out_vld,
  input  logic                    io_out_rdy,
  input  logic                    io_in_vld,
  output logic                    busy,
  output logic [IW-1:0]           cur_core
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OUT  = 2'd1;
  localparam logic [1:0] ST_IN   = 2'd2;

  logic [1:0]           state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        idx;
  logic signed [DW-1:0] io_out_p1;
  logic                 vld_p1;

  logic signed [DW-1:0] words [NCORE];
  logic [NCORE-1:0]     req_any;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        cand;
  logic [NCORE-1:0]     own_onehot;

  // Index following i, wrapping from the last core back to core 0.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) == NCORE - 1) return '0;
    else                      return i + 1'b1;
  endfunction

  for (genvar g = 0; g < NCORE; g++) begin : g_unpack
    assign words[g] = out_data[g*DW +: DW];
  end

  assign req_any = out_req | in_req;

  // Rotating scan: first requester at or after ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = ptr;
    for (int k = 0; k < NCORE; k++) begin
      if (!sel_found && req_any[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign own_onehot = {{(NCORE-1){1'b0}}, 1'b1} << idx;

  // Grants are combinational, valid only in the handshake cycle, and
  // suppressed while rst is high so a reset cycle never hands out the bus.
  // An input grant also needs the owner to still be asking for the word.
  assign out_gnt = (!rst && state == ST_OUT && io_out_rdy) ? own_onehot : '0;
  assign in_gnt  = (!rst && state == ST_IN && io_in_vld && in_req[idx])
                   ? own_onehot : '0;

  // ---- stage p1: arbitration state and captured output word ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      idx       <= '0;
      io_out_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            idx <= sel_idx;
            // Output wins over input when the same core asks for both.
            if (out_req[sel_idx]) begin
              io_out_p1 <= words[sel_idx];
              vld_p1    <= 1'b1;
              state     <= ST_OUT;
            end else begin
              state <= ST_IN;
            end
          end
        end
        ST_OUT: begin
          // The word was captured on entry; out_req/out_data are ignored here.
          if (io_out_rdy) begin
            vld_p1 <= 1'b0;
            ptr    <= wrap_inc(idx);
            state  <= ST_IDLE;
          end
        end
        ST_IN: begin
          if (!in_req[idx]) begin
            // Owner withdrew before the word arrived: release, ptr unchanged.
            state <= ST_IDLE;
          end else if (io_in_vld) begin
            ptr   <= wrap_inc(idx);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_out     = io_out_p1;
  assign io_out_vld = vld_p1;
  assign busy       = (state != ST_IDLE);
  assign cur_core   = idx;

endmodule

// File: tb/tb_core_io_arbiter.sv
module tb_core_io_arbiter;

  localparam int NCORE = 25;
  localparam int DW    = 32;
  localparam int IW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCORE-1:0]     out_req;
  logic [NCORE*DW-1:0]  out_data;
  logic [NCORE-1:0]     in_req;
  logic [NCORE-1:0]     out_gnt;
  logic [NCORE-1:0]     in_gnt;
  logic signed [DW-1:0] io_out;
  logic                 io_out_vld;
  logic                 io_out_rdy;
  logic                 io_in_vld;
  logic                 busy;
  logic [IW-1:0]        cur_core;

  int tests = 0;
  int fails = 0;

  core_io_arbiter #(.NCORE(NCORE), .DW(DW), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_req    (out_req),
    .out_data   (out_data),
    .in_req     (in_req),
    .out_gnt    (out_gnt),
    .in_gnt     (in_gnt),
    .io_out     (io_out),
    .io_out_vld (io_out_vld),
    .io_out_rdy (io_out_rdy),
    .io_in_vld  (io_in_vld),
    .busy       (busy),
    .cur_core   (cur_core)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NCORE-1:0] bit_of(input int i);
    logic [NCORE-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    out_req    = '0;
    in_req     = '0;
    out_data   = '0;
    io_out_rdy = 1'b0;
    io_in_vld  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    out_req    = bit_of(4);
    in_req     = bit_of(6);
    out_data   = '1;
    io_out_rdy = 1'b1;
    io_in_vld  = 1'b1;
    tick();
    tick();
    tests++; if (io_out !== 32'sd0) begin fails++; $display("FAIL reset_io_out: got %h want 0", io_out); end
    tests++; if (io_out_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", io_out_vld); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (cur_core !== 5'd0) begin fails++; $display("FAIL reset_cur_core: got %0d want 0", cur_core); end
    tests++; if ((out_gnt | in_gnt) !== '0) begin fails++; $display("FAIL reset_gnt: got %h/%h want 0", out_gnt, in_gnt); end
    do_reset();
  endtask

  task automatic test_single_out();
    do_reset();
    out_req = bit_of(3);
    out_data[3*DW +: DW] = 32'h000000A5;
    io_out_rdy = 1'b1;
    tick();
    tests++; if (io_out !== 32'sh000000A5) begin fails++; $display("FAIL single_io_out: got %h want 000000a5", io_out); end
    tests++; if (io_out_vld !== 1'b1) begin fails++; $display("FAIL single_vld: got %b want 1", io_out_vld); end
    tests++; if (out_gnt !== 25'h8) begin fails++; $display("FAIL single_gnt: got %h want 0000008", out_gnt); end
    tests++; if (cur_core !== 5'd3) begin fails++; $display("FAIL single_cur_core: got %0d want 3", cur_core); end
    out_req = '0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", busy); end
    tests++; if (io_out_vld !== 1'b0) begin fails++; $display("FAIL single_vld_after: got %b want 0", io_out_vld); end
  endtask

  task automatic test_all_out();
    int n_gnt;
    do_reset();
    out_req = '1;
    for (int i = 0; i < NCORE; i++) out_data[i*DW +: DW] = i;
    io_out_rdy = 1'b1;
    n_gnt = 0;
    for (int n = 0; n < 26; n++) begin
      tick();
      tests++; if (io_out !== 32'(n % NCORE)) begin fails++; $display("FAIL all_io_out[%0d]: got %0d want %0d", n, io_out, n % NCORE); end
      tests++; if (out_gnt !== bit_of(n % NCORE)) begin fails++; $display("FAIL all_gnt[%0d]: got %h want %h", n, out_gnt, bit_of(n % NCORE)); end
      if (out_gnt != '0) n_gnt++;
      tick();
      tests++; if (out_gnt !== '0 || busy !== 1'b0) begin fails++; $display("FAIL all_idle[%0d]: gnt %h busy %b want 0/0", n, out_gnt, busy); end
      if (n == 24) begin
        tests++; if (n_gnt !== 25) begin fails++; $display("FAIL all_count_50cyc: got %0d want 25", n_gnt); end
      end
    end
    out_req = '0;
  endtask

  task automatic test_out_stall();
    do_reset();
    out_req = bit_of(5);
    out_data[5*DW +: DW] = 32'h00001234;
    io_out_rdy = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) out_data[5*DW +: DW] = 32'hDEADBEEF;
      #1;
      tests++; if (io_out !== 32'sh00001234 || io_out_vld !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d]: got %h/%b want 00001234/1", i, io_out, io_out_vld); end
      tests++; if (out_gnt !== '0) begin fails++; $display("FAIL stall_nognt[%0d]: got %h want 0", i, out_gnt); end
      tick();
    end
    io_out_rdy = 1'b1;
    #1;
    tests++; if (out_gnt !== bit_of(5)) begin fails++; $display("FAIL stall_gnt: got %h want %h", out_gnt, bit_of(5)); end
    out_req = '0;
    tick();
    tests++; if (busy !== 1'b0 || io_out_vld !== 1'b0) begin fails++; $display("FAIL stall_release: busy %b vld %b want 0/0", busy, io_out_vld); end
  endtask

  task automatic test_in_req();
    do_reset();
    in_req = bit_of(7);
    tick();
    tests++; if (busy !== 1'b1 || cur_core !== 5'd7) begin fails++; $display("FAIL in_owner: busy %b core %0d want 1/7", busy, cur_core); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (in_gnt !== '0) begin fails++; $display("FAIL in_early[%0d]: got %h want 0", i, in_gnt); end
      tick();
    end
    io_in_vld = 1'b1;
    #1;
    tests++; if (in_gnt !== bit_of(7)) begin fails++; $display("FAIL in_gnt: got %h want %h", in_gnt, bit_of(7)); end
    tests++; if (out_gnt !== '0) begin fails++; $display("FAIL in_no_out_gnt: got %h want 0", out_gnt); end
    tick();
    io_in_vld = 1'b0;
    in_req = '0;
    #1;
    tests++; if (in_gnt !== '0 || busy !== 1'b0) begin fails++; $display("FAIL in_after: gnt %h busy %b want 0/0", in_gnt, busy); end
    io_in_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if ((in_gnt | out_gnt) !== '0 || busy !== 1'b0) begin fails++; $display("FAIL in_noreq[%0d]: gnt %h/%h busy %b want 0", i, in_gnt, out_gnt, busy); end
    end
    io_in_vld = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    io_out_rdy = 1'b1;
    out_req = bit_of(23);
    tick();
    tests++; if (out_gnt !== bit_of(23)) begin fails++; $display("FAIL wrap_pre: got %h want %h", out_gnt, bit_of(23)); end
    out_req = '0;
    tick();
    out_req = bit_of(24) | bit_of(0);
    out_data[24*DW +: DW] = 32'h00000018;
    out_data[0 +: DW] = 32'hFFFFFFFF;
    tick();
    tests++; if (cur_core !== 5'd24 || io_out !== 32'sh00000018) begin fails++; $display("FAIL wrap_first: core %0d out %h want 24/00000018", cur_core, io_out); end
    out_req = bit_of(0);
    tick();
    tick();
    tests++; if (cur_core !== 5'd0 || io_out !== -32'sd1 || out_gnt !== bit_of(0)) begin fails++; $display("FAIL wrap_second: core %0d out %h gnt %h want 0/ffffffff/1", cur_core, io_out, out_gnt); end
    out_req = '0;
    tick();

    do_reset();
    io_out_rdy = 1'b1;
    out_req = bit_of(2);
    in_req = bit_of(2);
    tick();
    tests++; if (out_gnt !== bit_of(2) || in_gnt !== '0) begin fails++; $display("FAIL both_out_first: gnt %h/%h want %h/0", out_gnt, in_gnt, bit_of(2)); end
    out_req = '0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL both_idle: got %b want 0", busy); end
    tick();
    tests++; if (busy !== 1'b1 || cur_core !== 5'd2 || in_gnt !== '0) begin fails++; $display("FAIL both_in_owner: busy %b core %0d gnt %h want 1/2/0", busy, cur_core, in_gnt); end
    io_in_vld = 1'b1;
    #1;
    tests++; if (in_gnt !== bit_of(2) || out_gnt !== '0) begin fails++; $display("FAIL both_in_gnt: got %h/%h want %h/0", in_gnt, out_gnt, bit_of(2)); end
    tick();
    io_in_vld = 1'b0;
    in_req = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    io_out_rdy = 1'b1;
    out_req = bit_of(12);
    tick();
    out_req = '0;
    tick();
    out_req = bit_of(9) | bit_of(15);
    out_data[9*DW +: DW]  = 32'h00000099;
    out_data[15*DW +: DW] = 32'h00000015;
    io_out_rdy = 1'b0;
    tick();
    tests++; if (cur_core !== 5'd15 || io_out_vld !== 1'b1) begin fails++; $display("FAIL rst_pre_owner: core %0d vld %b want 15/1", cur_core, io_out_vld); end
    rst = 1'b1;
    io_out_rdy = 1'b1;
    #1;
    tests++; if (out_gnt !== '0) begin fails++; $display("FAIL rst_forced_gnt: got %h want 0", out_gnt); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (io_out_vld !== 1'b0 || busy !== 1'b0 || out_gnt !== '0) begin fails++; $display("FAIL rst_dropped: vld %b busy %b gnt %h want 0/0/0", io_out_vld, busy, out_gnt); end
    tick();
    tests++; if (cur_core !== 5'd9 || io_out !== 32'sh00000099 || out_gnt !== bit_of(9)) begin fails++; $display("FAIL rst_regrant: core %0d out %h gnt %h want 9/00000099/%h", cur_core, io_out, out_gnt, bit_of(9)); end
    out_req = '0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    out_req    = '0;
    in_req     = '0;
    out_data   = '0;
    io_out_rdy = 1'b0;
    io_in_vld  = 1'b0;
    test_reset();
    test_single_out();
    test_all_out();
    test_out_stall();
    test_in_req();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Grants must stay one-hot or zero and never overlap between directions.
  always @(negedge clk) begin
    if (!$onehot0(out_gnt | in_gnt) || ((out_gnt != '0) && (in_gnt != '0))) begin
      tests++;
      fails++;
      $display("FAIL gnt_onehot: got %h/%h want one-hot or zero", out_gnt, in_gnt);
    end
  end

endmodule
